// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_propagate_adder.sv
// One-nibble adder with carry in/out; the serial adder reuses it once per RUN cycle.
module propagate_adder
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a shared 4-bit adder,
// carry chained through a register, valid/ready on both sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDXW    = $clog2(NIBBLES) + 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic [IDXW-1:0]  idx;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_carry;

  assign nib_a = a_reg[NIB_W*idx +: NIB_W];
  assign nib_b = b_reg[NIB_W*idx +: NIB_W];

  propagate_adder u_adder (
    .a     (nib_a),
    .b     (nib_b),
    .cin   (carry_reg),
    .sum   (nib_sum),
    .carry (nib_carry)
  );

  // in_ready is registered so it stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
            in_ready  <= 1'b0;
            state     <= S_RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          sum_reg[NIB_W*idx +: NIB_W] <= nib_sum;
          carry_reg                   <= nib_carry;
          // idx parks on the last nibble instead of wrapping.
          if (idx == IDX_LAST) begin
            cout      <= nib_carry;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   results = 0;
  int   n_expected = 0;
  int   last_acc = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: accepts, latency and result handshakes are all seen on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) checkOutput("rise_without_accept", 1, 0);
        else checkOutput("latency", cyc - acc_q.pop_front(), 4);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sum", {16'h0, sum}, {16'h0, e.s});
          checkOutput("cout", {31'h0, cout}, {31'h0, e.c});
        end
        results++;
      end
      prev_valid <= out_valid;
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                               input logic tc, input bit hold);
    logic [WIDTH:0] full;
    int n;
    full = {1'b0, ta} + {1'b0, tb_v} + {{WIDTH{1'b0}}, tc};
    exp_q.push_back({full[WIDTH-1:0], full[WIDTH]});
    n_expected++;
    a = ta;
    b = tb_v;
    cin = tc;
    in_valid = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 50) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (n == 100) checkOutput("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Abort at idx=2, check the cleared state, then prove the block recovers.
  task automatic resetMidOp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v);
    applyStimulus(ta, tb_v, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    n_expected--;
    checkOutput("rst_out_valid", {31'h0, out_valid}, 0);
    checkOutput("rst_sum", {16'h0, sum}, 0);
    checkOutput("rst_cout", {31'h0, cout}, 0);
    checkOutput("rst_busy", {31'h0, busy}, 0);
    checkOutput("rst_in_ready", {31'h0, in_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", {31'h0, in_ready}, 1);
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0);
    waitDrain();
  endtask

  initial begin
    int n;
    int t0;
    #1;
    checkOutput("reset_in_ready", {31'h0, in_ready}, 0);
    checkOutput("reset_out_valid", {31'h0, out_valid}, 0);
    checkOutput("reset_sum", {16'h0, sum}, 0);
    checkOutput("reset_cout", {31'h0, cout}, 0);
    checkOutput("reset_busy", {31'h0, busy}, 0);
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_in_ready", {31'h0, in_ready}, 1);

    out_ready = 1'b1;
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    checkOutput("run_busy", {31'h0, busy}, 1);
    checkOutput("run_in_ready", {31'h0, in_ready}, 0);
    waitDrain();
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    waitDrain();
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    waitDrain();

    // Backpressure: result must hold while new operands are offered and ignored.
    out_ready = 1'b0;
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (n == 50) checkOutput("done_timeout", 0, 1);
    a = 16'hDEAD;
    b = 16'hBEEF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", {31'h0, out_valid}, 1);
      checkOutput("bp_sum", {16'h0, sum}, 32'h1000);
      checkOutput("bp_cout", {31'h0, cout}, 0);
      checkOutput("bp_in_ready", {31'h0, in_ready}, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    waitDrain();
    applyStimulus(16'h7FFF, 16'h0001, 1'b1, 1'b0);
    waitDrain();

    // Back-to-back with in_valid held high: one accept every 6 cycles.
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b1);
    t0 = last_acc;
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b1);
    checkOutput("b2b_interval1", last_acc - t0, 6);
    t0 = last_acc;
    applyStimulus(16'h1111, 16'hEEEE, 1'b1, 1'b1);
    checkOutput("b2b_interval2", last_acc - t0, 6);
    in_valid = 1'b0;
    waitDrain();

    resetMidOp(16'hFFFF, 16'h0001);
    resetMidOp(16'h1234, 16'h4321);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_empty", exp_q.size(), 0);
    checkOutput("result_count", results, n_expected);
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
